// File: rtl/benes_ingress_ctrl.sv
// Ingress FIFO feeding a 5-stage Benes network with per-stage skewed switch settings.
// Head issues every non-empty cycle; out_valid lands NET_LAT+2 edges after acceptance into an empty FIFO.
module benes_ingress_ctrl #(
  parameter int DEPTH   = 4,
  parameter int NET_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_data [7:0],
  input  logic [3:0]             in_cfg [4:0],
  output logic [3:0]             net_i_port [7:0],
  output logic [3:0]             net_switch_set [4:0],
  input  logic [3:0]             net_o_port [7:0],
  output logic                   out_valid,
  output logic [3:0]             out_data [7:0],
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            issue_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]         mem_d [DEPTH-1:0][7:0];
  logic [3:0]         mem_c [DEPTH-1:0][4:0];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push;
  logic               issue;
  logic               issue_q;
  logic [NET_LAT-1:0] vld_sr;

  assign in_ready = (occupancy < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign issue    = (occupancy != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < 8; i++) mem_d[wr_ptr][i] <= in_data[i];
      for (int j = 0; j < 5; j++) mem_c[wr_ptr][j] <= in_cfg[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      issue_cnt <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        issue_cnt <= issue_cnt + 16'd1;
      end
      case ({push, issue})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign net_i_port[i] = issue ? mem_d[rd_ptr][i] : 4'd0;
  end

  assign net_switch_set[0] = issue ? mem_c[rd_ptr][0] : 4'd0;

  // Stage k sees the word issued k cycles ago; bubbles carry a zero setting.
  for (genvar k = 1; k < 5; k++) begin : g_skew
    logic [3:0] sr [k];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < k; d++) sr[d] <= '0;
      end else begin
        sr[0] <= issue ? mem_c[rd_ptr][k] : 4'd0;
        for (int d = 1; d < k; d++) sr[d] <= sr[d-1];
      end
    end
    assign net_switch_set[k] = sr[k-1];
  end

  // The network captures i_port at the end of the issue cycle; its NET_LAT ranks follow that capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q   <= 1'b0;
      vld_sr    <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 8; i++) out_data[i] <= '0;
    end else begin
      issue_q   <= issue;
      vld_sr[0] <= issue_q;
      for (int i = 1; i < NET_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      out_valid <= vld_sr[NET_LAT-1];
      if (vld_sr[NET_LAT-1]) begin
        for (int i = 0; i < 8; i++) out_data[i] <= net_o_port[i];
      end
    end
  end

endmodule
